// File: rtl/trdb_reg_ctrl.sv
// trdb_reg_ctrl: bus-mapped trace configuration, per-channel trace-enable FSMs and stall counters
module trdb_reg_ctrl #(
    parameter int unsigned NrChannels = 4,
    parameter int unsigned AddrWidth  = 4,
    parameter int unsigned CntWidth   = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  reg_req_i,
    input  logic                  reg_we_i,
    input  logic [AddrWidth-1:0]  reg_addr_i,
    input  logic [31:0]           reg_wdata_i,
    output logic [31:0]           reg_rdata_o,
    output logic                  reg_rvalid_o,
    output logic                  reg_error_o,
    input  logic [NrChannels-1:0] trace_req_on_i,
    input  logic [NrChannels-1:0] trace_req_off_i,
    input  logic                  encapsulator_ready_i,
    output logic [NrChannels-1:0] trace_activated_o,
    output logic [NrChannels-1:0] trace_enable_o,
    output logic [NrChannels-1:0] trace_stalled_o,
    output logic                  nocontext_o,
    output logic                  notime_o,
    output logic                  delta_address_o,
    output logic                  encoder_mode_o
);
    typedef enum logic [1:0] {OFF, ARMED, TRACING, STALLED} state_e;
    localparam logic [CntWidth-1:0] CntMax = '1;
    localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);
    state_e                state_q [NrChannels];
    state_e                state_d [NrChannels];
    logic [CntWidth-1:0]   cnt_q [NrChannels];
    logic [CntWidth-1:0]   cnt_d [NrChannels];
    logic [NrChannels-1:0] act_q, act_d, on_q, off_q;
    logic [NrChannels-1:0] rise_on, rise_off, en, stl, inc, clr;
    logic                  nocontext_q, nocontext_d, notime_q, notime_d, delta_q, delta_d;
    logic                  rdy_q, rise_rdy, fall_rdy, wr;
    logic                  rvalid_q, error_q, error_d;
    logic [31:0]           rdata_q, rdata_d, addr, ctrl_word, status_word;
    assign addr     = 32'(reg_addr_i);
    assign wr       = reg_req_i & reg_we_i;
    assign rise_on  = trace_req_on_i & ~on_q;
    assign rise_off = trace_req_off_i & ~off_q;
    assign rise_rdy = encapsulator_ready_i & ~rdy_q;
    assign fall_rdy = ~encapsulator_ready_i & rdy_q;
    // register file: read mux, error decode and CTRL write
    always_comb begin
        ctrl_word = '0;
        ctrl_word[NrChannels-1:0] = act_q;
        ctrl_word[16] = nocontext_q;
        ctrl_word[17] = notime_q;
        ctrl_word[18] = delta_q;
        status_word = '0;
        status_word[NrChannels-1:0] = en;
        status_word[16 +: NrChannels] = stl;
        rdata_d = '0;
        error_d = 1'b0;
        if (reg_req_i) begin
            if (addr == 32'd0) rdata_d = ctrl_word;
            else if (addr == 32'd1) begin
                rdata_d = status_word;
                error_d = reg_we_i;
            end else if (addr >= 32'd4 && addr < 32'(4 + NrChannels)) begin
                for (int c = 0; c < NrChannels; c++)
                    if (addr == 32'(4 + c)) rdata_d = 32'(cnt_q[c]);
            end else error_d = 1'b1;
        end
        act_d       = (wr && addr == 32'd0) ? reg_wdata_i[NrChannels-1:0] : act_q;
        nocontext_d = (wr && addr == 32'd0) ? reg_wdata_i[16] : nocontext_q;
        notime_d    = (wr && addr == 32'd0) ? reg_wdata_i[17] : notime_q;
        delta_d     = (wr && addr == 32'd0) ? reg_wdata_i[18] : delta_q;
    end
    // per-channel trace FSM next state and saturating stall counter
    always_comb begin
        inc = '0;
        clr = '0;
        en  = '0;
        stl = '0;
        for (int c = 0; c < NrChannels; c++) begin
            en[c]  = state_q[c] == TRACING;
            stl[c] = state_q[c] == STALLED;
            state_d[c] = !act_q[c] ? OFF :
                         state_q[c] == OFF ? ARMED :
                         (rise_off[c] && (en[c] || stl[c])) ? ARMED :
                         (fall_rdy && en[c]) ? STALLED :
                         (rise_rdy && stl[c]) ? TRACING :
                         (rise_on[c] && state_q[c] == ARMED) ? TRACING : state_q[c];
            inc[c] = act_q[c] && en[c] && !rise_off[c] && fall_rdy;
            clr[c] = wr && addr == 32'(4 + c);
            cnt_d[c] = clr[c] ? (inc[c] ? CntOne : '0) :
                       (inc[c] && cnt_q[c] != CntMax) ? cnt_q[c] + CntOne : cnt_q[c];
        end
    end
    // state registers; reset drops any pending bus response
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            act_q       <= '0;
            nocontext_q <= 1'b1;
            notime_q    <= 1'b1;
            delta_q     <= 1'b1;
            on_q        <= '0;
            off_q       <= '0;
            rdy_q       <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            error_q     <= 1'b0;
            for (int c = 0; c < NrChannels; c++) begin
                state_q[c] <= OFF;
                cnt_q[c]   <= '0;
            end
        end else begin
            act_q       <= act_d;
            nocontext_q <= nocontext_d;
            notime_q    <= notime_d;
            delta_q     <= delta_d;
            on_q        <= trace_req_on_i;
            off_q       <= trace_req_off_i;
            rdy_q       <= encapsulator_ready_i;
            rvalid_q    <= reg_req_i;
            rdata_q     <= rdata_d;
            error_q     <= error_d;
            for (int c = 0; c < NrChannels; c++) begin
                state_q[c] <= state_d[c];
                cnt_q[c]   <= cnt_d[c];
            end
        end
    end
    assign reg_rdata_o       = rdata_q;
    assign reg_rvalid_o      = rvalid_q;
    assign reg_error_o       = error_q;
    assign trace_activated_o = act_q;
    assign trace_enable_o    = en;
    assign trace_stalled_o   = stl;
    assign nocontext_o       = nocontext_q;
    assign notime_o          = notime_q;
    assign delta_address_o   = delta_q;
    assign encoder_mode_o    = 1'b0;
endmodule

// File: tb/tb_trdb_reg_ctrl.sv
// tb_trdb_reg_ctrl: directed and random stimulus checked against a cycle-level reference model
module tb_trdb_reg_ctrl;
    localparam int N = 4, AW = 4, CW = 2;
    localparam int CMAX = (1 << CW) - 1;
    localparam int S_OFF = 0, S_ARM = 1, S_TRC = 2, S_STL = 3;
    logic          clk = 1'b0, rst = 1'b1;
    logic          req = 1'b0, we = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [31:0]   wdata = '0;
    logic [N-1:0]  on = '0, off = '0;
    logic          rdy = 1'b1;
    logic [31:0]   rdata;
    logic          rvalid, err, noc, notm, dlt, emode;
    logic [N-1:0]  act_o, en_o, stl_o;
    int            n_chk = 0, n_pass = 0;
    int            m_act [N];
    int            m_st [N];
    int            m_cnt [N];
    bit            m_on [N];
    bit            m_off [N];
    bit            m_rdy, m_noc, m_not, m_dlt, m_rv, m_err;
    logic [31:0]   m_rd;

    trdb_reg_ctrl #(.NrChannels(N), .AddrWidth(AW), .CntWidth(CW)) dut (
        .clk_i(clk), .rst_i(rst),
        .reg_req_i(req), .reg_we_i(we), .reg_addr_i(addr), .reg_wdata_i(wdata),
        .reg_rdata_o(rdata), .reg_rvalid_o(rvalid), .reg_error_o(err),
        .trace_req_on_i(on), .trace_req_off_i(off), .encapsulator_ready_i(rdy),
        .trace_activated_o(act_o), .trace_enable_o(en_o), .trace_stalled_o(stl_o),
        .nocontext_o(noc), .notime_o(notm), .delta_address_o(dlt), .encoder_mode_o(emode)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic void model_reset();
        for (int c = 0; c < N; c++) begin
            m_act[c] = 0; m_st[c] = S_OFF; m_cnt[c] = 0; m_on[c] = 0; m_off[c] = 0;
        end
        m_rdy = 0; m_noc = 1; m_not = 1; m_dlt = 1; m_rv = 0; m_err = 0; m_rd = '0;
    endfunction

    function automatic logic [31:0] mask_of(input int which);
        logic [31:0] w = '0;
        for (int c = 0; c < N; c++) w[c] = (which == 0) ? (m_act[c] != 0) : (m_st[c] == which);
        return w;
    endfunction

    // advances the model by one clock using the inputs currently applied
    function automatic void model_step();
        int          a = int'(addr);
        bit          wr = req && we;
        bit          fall_r = !rdy && m_rdy;
        bit          rise_r = rdy && !m_rdy;
        logic [31:0] rd = '0;
        bit          er = 0;
        if (rst) begin
            model_reset();
            return;
        end
        if (req) begin
            if (a == 0) rd = mask_of(0) | {13'b0, m_dlt, m_not, m_noc, 16'b0};
            else if (a == 1) rd = mask_of(S_TRC) | (mask_of(S_STL) << 16);
            else if (a >= 4 && a < 4 + N) rd = m_cnt[a - 4];
            else er = 1;
            if (wr && a == 1) er = 1;
        end
        m_rv = req; m_rd = rd; m_err = er;
        for (int c = 0; c < N; c++) begin
            bit ron = on[c] && !m_on[c];
            bit roff = off[c] && !m_off[c];
            bit stall = 0;
            int s = m_st[c];
            if (m_act[c] == 0) s = S_OFF;
            else if (s == S_OFF) s = S_ARM;
            else if (roff && (s == S_TRC || s == S_STL)) s = S_ARM;
            else if (fall_r && s == S_TRC) begin s = S_STL; stall = 1; end
            else if (rise_r && s == S_STL) s = S_TRC;
            else if (ron && s == S_ARM) s = S_TRC;
            m_st[c] = s;
            if (wr && a == 4 + c) m_cnt[c] = stall ? 1 : 0;
            else if (stall && m_cnt[c] < CMAX) m_cnt[c]++;
            m_on[c] = on[c]; m_off[c] = off[c];
        end
        m_rdy = rdy;
        if (wr && a == 0) begin
            for (int c = 0; c < N; c++) m_act[c] = wdata[c];
            m_noc = wdata[16]; m_not = wdata[17]; m_dlt = wdata[18];
        end
    endfunction

    task automatic compare_all();
        check("rvalid", rvalid, m_rv);
        if (m_rv) begin
            check("rdata", rdata, m_rd);
            check("error", err, m_err);
        end
        check("activated", act_o, mask_of(0));
        check("enable", en_o, mask_of(S_TRC));
        check("stalled", stl_o, mask_of(S_STL));
        check("cfg", {emode, dlt, notm, noc}, {1'b0, m_dlt, m_not, m_noc});
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic bus(input bit w, input int a, input logic [31:0] d);
        req = 1'b1; we = w; addr = a[AW-1:0]; wdata = d;
        tick();
        req = 1'b0; we = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (3) tick();
        rst = 1'b0;
        check("rst_cfg", {noc, notm, dlt}, 3'b111);
        bus(0, 0, 0);
        check("ctrl_rst", rdata, 32'h0007_0000);
        check("ctrl_rst_err", err, 0);
        bus(0, 1, 0);
        check("status_rst", rdata, 0);
        bus(1, 0, 1);
        tick();
        on[0] = 1'b1;
        tick();
        check("on_enable", en_o, 4'b0001);
        bus(0, 1, 0);
        check("status_on", rdata, 32'h1);
        for (int i = 0; i < 3; i++) begin
            rdy = 1'b0;
            tick();
            check("stall_set", stl_o, 4'b0001);
            rdy = 1'b1;
            tick();
            check("stall_clr", stl_o, 4'b0000);
        end
        bus(0, 4, 0);
        check("cnt3", rdata, 3);
        bus(1, 4, 0);
        bus(0, 4, 0);
        check("cnt_cleared", rdata, 0);
        on[0] = 1'b0;
        tick();
        on[0] = 1'b1; off[0] = 1'b1;
        tick();
        check("onoff_armed", en_o, 4'b0000);
        on[0] = 1'b0; off[0] = 1'b0;
        bus(1, 0, 0);
        tick();
        check("deact", act_o, 4'b0000);
        on[0] = 1'b1;
        tick();
        tick();
        check("off_ignores_on", en_o, 4'b0000);
        on[0] = 1'b0;
        bus(1, 0, 1);
        tick();
        on[0] = 1'b1;
        tick();
        on[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rdy = 1'b0;
            tick();
            rdy = 1'b1;
            tick();
        end
        bus(0, 4, 0);
        check("cnt_sat", rdata, 3);
        rdy = 1'b0;
        bus(1, 4, 0);
        rdy = 1'b1;
        tick();
        bus(0, 4, 0);
        check("cnt_clr_inc", rdata, 1);
        bus(0, 2, 0);
        check("rsvd_rdata", rdata, 0);
        check("rsvd_err", err, 1);
        bus(0, 15, 0);
        check("unmapped_err", err, 1);
        bus(1, 1, 32'hFFFF_FFFF);
        check("ro_write_err", err, 1);
        bus(0, 1, 0);
        check("status_kept", rdata, 32'h1);
        req = 1'b1; rst = 1'b1;
        tick();
        check("rst_drops_rsp", rvalid, 0);
        req = 1'b0; rst = 1'b0;
        tick();
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(499) == 0);
            req = ($urandom_range(2) == 0);
            we = $urandom_range(1);
            addr = AW'($urandom_range(15));
            wdata = $urandom;
            if ($urandom_range(3) != 0) wdata[N-1:0] = '1;
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(3) == 0) on[c] = ~on[c];
                if ($urandom_range(5) == 0) off[c] = ~off[c];
            end
            if ($urandom_range(4) == 0) rdy = ~rdy;
            tick();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
